// File: rtl/alu_issue_arbiter_pkg.sv
// Shared types and constants for the ALU issue arbiter and its ID-stage neighbours.
// OH_DIV must match the op-handle encoding produced by id.
package alu_issue_arbiter_pkg;

  localparam int NUM_THREADS = 4;
  localparam int NUM_ALUS    = 3;
  localparam int OH_W        = 7;
  localparam int TID_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;
  localparam int ALU_W       = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1;

  typedef logic [OH_W-1:0]  oh_t;
  typedef logic [TID_W-1:0] tid_t;
  typedef logic [ALU_W-1:0] alu_id_t;

  localparam oh_t OH_DIV = 7'd38;

endpackage

// File: rtl/alu_issue_arbiter_if.sv
// ID->EX issue bundle: per-thread op handles in, per-thread grants and per-ALU issue info out.
interface alu_issue_arbiter_if;
  import alu_issue_arbiter_pkg::*;

  oh_t     [NUM_THREADS-1:0] oh;
  logic    [NUM_THREADS-1:0] grant;
  logic    [NUM_THREADS-1:0] hold;
  alu_id_t [NUM_THREADS-1:0] alu_sel;
  logic    [NUM_ALUS-1:0]    alu_valid;
  tid_t    [NUM_ALUS-1:0]    alu_thread;
  logic    [NUM_ALUS-1:0]    alu_busy;

  modport master (
    output oh,
    input  grant, hold, alu_sel, alu_valid, alu_thread, alu_busy
  );

  modport slave (
    input  oh,
    output grant, hold, alu_sel, alu_valid, alu_thread, alu_busy
  );

endinterface

// File: rtl/alu_busy_ctr.sv
// Per-ALU occupancy counter for multi-cycle DIV ops; the ALU is free whenever the count reads 0.
module alu_busy_ctr
  import alu_issue_arbiter_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  tid_t load_tid,
  output logic busy,
  output tid_t owner
);

  localparam int CNT_W = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;

  logic [CNT_W-1:0] cnt_r;
  tid_t             owner_r;

  // Load on a DIV grant, then count down to free the ALU.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r   <= '0;
      owner_r <= '0;
    end else if (load) begin
      cnt_r   <= CNT_W'(DIV_LAT - 1);
      owner_r <= load_tid;
    end else if (cnt_r != '0) begin
      cnt_r   <= cnt_r - CNT_W'(1);
    end else begin
      cnt_r   <= cnt_r;
    end
  end

  assign busy  = (cnt_r != '0);
  assign owner = owner_r;

endmodule

// File: rtl/alu_issue_arbiter.sv
// Round-robin issue of per-thread decoded ops onto a pool of shared ALUs at the ID->EX boundary.
// Grants are combinational from the current op handles and the registered pointer/busy state.
module alu_issue_arbiter
  import alu_issue_arbiter_pkg::*;
#(
  parameter int DIV_LAT = 8
) (
  input logic                clk,
  input logic                rst,
  alu_issue_arbiter_if.slave arb
);

  tid_t                     rr_ptr_r;
  logic    [NUM_ALUS-1:0]   alu_busy_s;
  tid_t    [NUM_ALUS-1:0]   div_owner_s;
  logic    [NUM_ALUS-1:0]   div_load_s;
  logic    [NUM_ALUS-1:0]   alu_valid_s;
  tid_t    [NUM_ALUS-1:0]   alu_thread_s;
  logic [NUM_THREADS-1:0]   oh_nz_s;
  logic [NUM_THREADS-1:0]   blocked_s;
  logic [NUM_THREADS-1:0]   req_s;
  logic [NUM_THREADS-1:0]   grant_s;
  alu_id_t [NUM_THREADS-1:0] alu_sel_s;
  tid_t                     last_tid_s;
  logic                     any_grant_s;

  for (genvar a = 0; a < NUM_ALUS; a++) begin : g_alu
    alu_busy_ctr #(.DIV_LAT(DIV_LAT)) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (div_load_s[a]),
      .load_tid (alu_thread_s[a]),
      .busy     (alu_busy_s[a]),
      .owner    (div_owner_s[a])
    );
  end

  // A thread with a DIV still in flight may not issue, keeping its ops in order.
  always_comb begin
    blocked_s = '0;
    oh_nz_s   = '0;
    req_s     = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      for (int a = 0; a < NUM_ALUS; a++) begin
        blocked_s[t] = blocked_s[t] | (alu_busy_s[a] & (div_owner_s[a] == tid_t'(t)));
      end
      oh_nz_s[t] = (arb.oh[t] != '0);
      req_s[t]   = oh_nz_s[t] & ~blocked_s[t];
    end
  end

  // Scan from rr_ptr; each requester takes the lowest-index free ALU not yet taken.
  always_comb begin
    tid_t t;
    logic found;
    logic hit;
    t            = '0;
    found        = 1'b0;
    hit          = 1'b0;
    grant_s      = '0;
    alu_sel_s    = '0;
    alu_valid_s  = '0;
    alu_thread_s = '0;
    div_load_s   = '0;
    last_tid_s   = rr_ptr_r;
    any_grant_s  = 1'b0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      t     = tid_t'((int'(rr_ptr_r) + i) % NUM_THREADS);
      found = 1'b0;
      for (int a = 0; a < NUM_ALUS; a++) begin
        hit             = req_s[t] & ~found & ~alu_busy_s[a] & ~alu_valid_s[a];
        found           = found | hit;
        alu_valid_s[a]  = alu_valid_s[a] | hit;
        alu_thread_s[a] = hit ? t : alu_thread_s[a];
        alu_sel_s[t]    = hit ? alu_id_t'(a) : alu_sel_s[t];
        div_load_s[a]   = div_load_s[a] | (hit & (arb.oh[t] == OH_DIV) & (DIV_LAT > 1));
      end
      grant_s[t]  = found;
      last_tid_s  = found ? t : last_tid_s;
      any_grant_s = any_grant_s | found;
    end
  end

  // Pointer moves just past the last thread served; frozen when nothing issues.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_r <= '0;
    end else if (any_grant_s) begin
      rr_ptr_r <= tid_t'((int'(last_tid_s) + 1) % NUM_THREADS);
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end

  // All outputs are held at zero while reset is asserted.
  always_comb begin
    if (rst) begin
      arb.grant      = grant_s;
      arb.hold       = oh_nz_s & ~grant_s;
      arb.alu_sel    = alu_sel_s;
      arb.alu_valid  = alu_valid_s;
      arb.alu_thread = alu_thread_s;
      arb.alu_busy   = alu_busy_s;
    end else begin
      arb.grant      = '0;
      arb.hold       = '0;
      arb.alu_sel    = '0;
      arb.alu_valid  = '0;
      arb.alu_thread = '0;
      arb.alu_busy   = '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter: round-robin issue, DIV occupancy, reset and idle cases.
module tb_alu_issue_arbiter;
  import alu_issue_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   chk_cnt = 0;
  int   err_cnt = 0;

  alu_issue_arbiter_if bus ();

  alu_issue_arbiter #(.DIV_LAT(8)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [3:0] h,
                            input logic [7:0] sel, input logic [2:0] v,
                            input logic [5:0] thr, input logic [2:0] busy);
    #1;
    chk({tag, ".grant"},      32'(bus.grant),      32'(g));
    chk({tag, ".hold"},       32'(bus.hold),       32'(h));
    chk({tag, ".alu_sel"},    32'(bus.alu_sel),    32'(sel));
    chk({tag, ".alu_valid"},  32'(bus.alu_valid),  32'(v));
    chk({tag, ".alu_thread"}, 32'(bus.alu_thread), 32'(thr));
    chk({tag, ".alu_busy"},   32'(bus.alu_busy),   32'(busy));
  endtask

  task automatic chk_rr(input string tag, input logic [1:0] exp);
    chk(tag, 32'(dut.rr_ptr_r), 32'(exp));
  endtask

  initial begin
    rst    = 1'b0;
    bus.oh = {7'd4, 7'd3, 7'd2, 7'd1};
    tick();
    tick();
    expect_out("rst", 4'h0, 4'h0, 8'h00, 3'b000, 6'h00, 3'b000);
    chk_rr("rst.rr", 2'd0);

    // Three of four threads win from rr_ptr=0.
    rst    = 1'b1;
    bus.oh = {7'd36, 7'd19, 7'd28, 7'd33};
    expect_out("c1", 4'b0111, 4'b1000, 8'h24, 3'b111, 6'h24, 3'b000);
    tick();
    chk_rr("c1.rr", 2'd3);
    expect_out("c2", 4'b1011, 4'b0100, 8'h09, 3'b111, 6'h13, 3'b000);
    tick();
    chk_rr("c2.rr", 2'd2);

    // Thread 0 DIV pins ALU0 for seven cycles while thread 1 uses ALU1.
    bus.oh = {7'd0, 7'd0, 7'd0, 7'd38};
    expect_out("c3.div", 4'b0001, 4'b0000, 8'h00, 3'b001, 6'h00, 3'b000);
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.oh = {7'd0, 7'd0, 7'd5, 7'd38};
      expect_out($sformatf("c3.busy%0d", c), 4'b0010, 4'b0001, 8'h04, 3'b010, 6'h04, 3'b001);
    end
    tick();
    expect_out("c3.free", 4'b0011, 4'b0000, 8'h04, 3'b011, 6'h04, 3'b000);

    // Reset three cycles into the re-issued DIV abandons it.
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.oh = {7'd0, 7'd0, 7'd0, 7'd38};
      expect_out($sformatf("c5.run%0d", c), 4'b0000, 4'b0001, 8'h00, 3'b000, 6'h00, 3'b001);
    end
    tick();
    rst    = 1'b0;
    bus.oh = {7'd4, 7'd3, 7'd2, 7'd1};
    expect_out("c5.inrst", 4'h0, 4'h0, 8'h00, 3'b000, 6'h00, 3'b000);
    tick();
    rst = 1'b1;
    chk_rr("c5.rr", 2'd0);
    expect_out("c5.post", 4'b0111, 4'b1000, 8'h24, 3'b111, 6'h24, 3'b000);

    // Three DIVs fill every ALU; everyone holds and the pointer freezes.
    tick();
    chk_rr("c4.rr0", 2'd3);
    bus.oh = {7'd0, 7'd38, 7'd38, 7'd38};
    expect_out("c4.issue", 4'b0111, 4'b0000, 8'h24, 3'b111, 6'h24, 3'b000);
    for (int c = 1; c <= 7; c++) begin
      tick();
      bus.oh = {7'd12, 7'd38, 7'd38, 7'd38};
      expect_out($sformatf("c4.full%0d", c), 4'b0000, 4'b1111, 8'h00, 3'b000, 6'h00, 3'b111);
      chk_rr($sformatf("c4.rr%0d", c), 2'd3);
    end
    tick();
    expect_out("c4.free", 4'b1011, 4'b0100, 8'h09, 3'b111, 6'h13, 3'b000);
    tick();
    chk_rr("c4.rr", 2'd2);

    // Idle: nothing issues and the pointer stays put.
    bus.oh = '0;
    for (int c = 0; c < 5; c++) begin
      expect_out($sformatf("c6.idle%0d", c), 4'b0000, 4'b0000, 8'h00, 3'b000, 6'h00, 3'b110);
      tick();
    end
    chk_rr("c6.rr", 2'd2);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
